// File: rtl/button_events.sv
// rtl/button_events.sv - per-channel press/release/long-press/auto-repeat event generator
//
// Turns debounced button levels into one-cycle event pulses. Each channel has
// its own small FSM and down-counter, and channels never interact.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   defined   : after the long-press delay, rpt pulses every RATE_CYCLES while held
//   undefined : no REPEAT state, rpt tied to 0, a single long_press per press
//
// Parameters
//   WIDTH        number of independent button channels
//   DELAY_CYCLES clk cycles from the press pulse to the long_press pulse (>= 2)
//   RATE_CYCLES  auto-repeat period in clk cycles (>= 2)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   btn_in       debounced levels, 1 = pressed, already synchronous to clk
//   btn_held     registered copy of btn_in
//   press        one-cycle pulse on a 0->1 transition
//   btn_release  one-cycle pulse on a 1->0 transition ("release" is a reserved word)
//   long_press   one-cycle pulse once a press has lasted DELAY_CYCLES
//   rpt          one-cycle auto-repeat pulses while held past DELAY_CYCLES
//
// All outputs are registered: an edge on btn_in shows up on press/btn_release
// one cycle later.

module button_events #(
    parameter int WIDTH        = 16,
    parameter int DELAY_CYCLES = 25000000,
    parameter int RATE_CYCLES  = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_held,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] btn_release,
    output logic [WIDTH-1:0] long_press,
    output logic [WIDTH-1:0] rpt
);

    localparam int MAX_CYCLES = (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DELAY_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LOAD = CNT_W'(RATE_CYCLES - 1);
`endif

`ifdef BTN_AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1
    } state_t;
`endif

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];

    logic [WIDTH-1:0] btn_held_q, btn_held_d;
    logic [WIDTH-1:0] press_q,    press_d;
    logic [WIDTH-1:0] rel_q,      rel_d;
    logic [WIDTH-1:0] long_q,     long_d;
`ifdef BTN_AUTO_REPEAT_EN
    logic [WIDTH-1:0] rpt_q,      rpt_d;
`else
    // Without auto-repeat the counter parks at 0 after expiry; this flag keeps
    // long_press from firing again on every following cycle of the same hold.
    logic [WIDTH-1:0] lp_done_q,  lp_done_d;
`endif

    always_comb begin
        btn_held_d = btn_in;
        press_d    = '0;
        rel_d      = '0;
        long_d     = '0;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_d      = '0;
`else
        lp_done_d  = lp_done_q;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (btn_in[i] && !btn_held_q[i]) begin
                        press_d[i] = 1'b1;
                        cnt_d[i]   = DLY_LOAD;
                        state_d[i] = ST_HELD;
                    end
                end
                ST_HELD: begin
                    // Release is tested first so it wins over a coinciding expiry.
                    if (!btn_in[i]) begin
                        rel_d[i]     = 1'b1;
                        cnt_d[i]     = '0;
                        state_d[i]   = ST_IDLE;
`ifndef BTN_AUTO_REPEAT_EN
                        lp_done_d[i] = 1'b0;
`endif
                    end else if (cnt_q[i] == '0) begin
`ifdef BTN_AUTO_REPEAT_EN
                        long_d[i]  = 1'b1;
                        rpt_d[i]   = 1'b1;
                        cnt_d[i]   = RPT_LOAD;
                        state_d[i] = ST_REPEAT;
`else
                        if (!lp_done_q[i]) begin
                            long_d[i]    = 1'b1;
                            lp_done_d[i] = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
`ifdef BTN_AUTO_REPEAT_EN
                ST_REPEAT: begin
                    if (!btn_in[i]) begin
                        rel_d[i]   = 1'b1;
                        cnt_d[i]   = '0;
                        state_d[i] = ST_IDLE;
                    end else if (cnt_q[i] == '0) begin
                        rpt_d[i] = 1'b1;
                        cnt_d[i] = RPT_LOAD;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_ONE;
                    end
                end
`endif
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            btn_held_q <= '0;
            press_q    <= '0;
            rel_q      <= '0;
            long_q     <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q      <= '0;
`else
            lp_done_q  <= '0;
`endif
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            btn_held_q <= btn_held_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            long_q     <= long_d;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q      <= rpt_d;
`else
            lp_done_q  <= lp_done_d;
`endif
        end
    end

    assign btn_held    = btn_held_q;
    assign press       = press_q;
    assign btn_release = rel_q;
    assign long_press  = long_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign rpt         = rpt_q;
`else
    assign rpt         = '0;
`endif

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - directed self-checking bench for button_events
module tb_button_events;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_held;
    logic [3:0] press;
    logic [3:0] btn_release;
    logic [3:0] long_press;
    logic [3:0] rpt;

    int test_cnt = 0;
    int fail_cnt = 0;

    button_events #(
        .WIDTH        (4),
        .DELAY_CYCLES (10),
        .RATE_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .btn_held    (btn_held),
        .press       (press),
        .btn_release (btn_release),
        .long_press  (long_press),
        .rpt         (rpt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare all five outputs for cycle c of the named scenario.
    task automatic check_cycle(input string sc, input int c,
                               input logic [3:0] e_held, input logic [3:0] e_press,
                               input logic [3:0] e_rel, input logic [3:0] e_long,
                               input logic [3:0] e_rpt);
        check($sformatf("%s.held c%0d", sc, c),  32'(btn_held),    32'(e_held));
        check($sformatf("%s.press c%0d", sc, c), 32'(press),       32'(e_press));
        check($sformatf("%s.rel c%0d", sc, c),   32'(btn_release), 32'(e_rel));
        check($sformatf("%s.long c%0d", sc, c),  32'(long_press),  32'(e_long));
        check($sformatf("%s.rpt c%0d", sc, c),   32'(rpt),         32'(e_rpt));
    endtask

    function automatic logic [3:0] m(input bit b, input logic [3:0] mask);
        return b ? mask : 4'h0;
    endfunction

    function automatic bit rpt_hit(input int c, input int first, input int last);
`ifdef BTN_AUTO_REPEAT_EN
        return (c >= first) && (c <= last) && (((c - first) % 4) == 0);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        reset  = 1'b1;
        btn_in = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_cycle("reset", 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // A: channel 0 held for cycles 0..29.
        for (int c = 0; c <= 34; c++) begin
            btn_in = (c < 30) ? 4'h1 : 4'h0;
            @(negedge clk);
            check_cycle("A", c, m(c >= 1 && c <= 30, 4'h1), m(c == 1, 4'h1),
                        m(c == 31, 4'h1), m(c == 11, 4'h1), m(rpt_hit(c, 11, 27), 4'h1));
            @(posedge clk);
            #1;
        end

        // B: channel 1 short press, cycles 0..4.
        for (int c = 0; c <= 12; c++) begin
            btn_in = (c < 5) ? 4'h2 : 4'h0;
            @(negedge clk);
            check_cycle("B", c, m(c >= 1 && c <= 5, 4'h2), m(c == 1, 4'h2),
                        m(c == 6, 4'h2), 4'h0, 4'h0);
            @(posedge clk);
            #1;
        end

        // C: channel 2 released on the very cycle the counter expires.
        for (int c = 0; c <= 20; c++) begin
            btn_in = (c < 10) ? 4'h4 : 4'h0;
            @(negedge clk);
            check_cycle("C", c, m(c >= 1 && c <= 10, 4'h4), m(c == 1, 4'h4),
                        m(c == 11, 4'h4), 4'h0, 4'h0);
            @(posedge clk);
            #1;
        end

        // D: all channels held, reset during cycles 6..7, released from cycle 29.
        for (int c = 0; c <= 32; c++) begin
            btn_in = (c < 29) ? 4'hF : 4'h0;
            reset  = (c == 6 || c == 7);
            @(negedge clk);
            check_cycle("D", c, m((c >= 1 && c <= 6) || (c >= 9 && c <= 29), 4'hF),
                        m(c == 1 || c == 9, 4'hF), m(c == 30, 4'hF),
                        m(c == 19, 4'hF), m(rpt_hit(c, 19, 27), 4'hF));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
